// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_mem_pkg                                                        |
// | Shared types and constants for the LC3 memory responder.           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package lc3_mem_pkg;

  localparam int unsigned c_DEF_MEM_DEPTH = 256;
  localparam int unsigned c_DEF_LATENCY   = 2;
  localparam int unsigned c_CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a word address falls outside a memory of the given depth.
  function automatic logic addr_oor(input logic [15:0] a, input int unsigned depth);
    return (32'(a) >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_mem_array                                                      |
// | 16-bit word storage: synchronous write, combinational read.        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module lc3_mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  // Contents are deliberately not reset so data survives a responder reset.
  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_mem_responder                                                  |
// | Fixed-latency memory responder for the LC3 MAR/MDR interface.      |
// | Optional macro LC3_MEM_OOR_ERR_EN enables out-of-range flagging.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = c_DEF_MEM_DEPTH,
  parameter int unsigned LATENCY   = c_DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memEN,
  input  logic        memWE,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        ready,
  output logic        err
);

  localparam int unsigned        c_AW       = $clog2(MEM_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [15:0]        r_addr;
  logic [15:0]        r_din;
  logic               r_we;
  logic [15:0]        r_dout;
  logic               w_capture;
  logic               w_load_dout;
  logic               w_done;
  logic               w_oor;
  logic               w_mem_we;
  logic [15:0]        w_rdata;
  logic               w_unused_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr <= addr;
        r_din  <= din;
        r_we   <= memWE;
      end
      if (w_load_dout) begin
        r_dout <= w_oor ? 16'h0000 : w_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_load_dout = 1'b0;
    case (r_state)
      IDLE: begin
        if (memEN) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = c_CNT_LOAD;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Read data is latched as DONE is entered so it is valid with ready.
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
          w_load_dout = ~r_we;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef LC3_MEM_OOR_ERR_EN
  assign w_oor = addr_oor(r_addr, MEM_DEPTH);
`else
  assign w_oor = 1'b0;
`endif

  // The write retires on the edge leaving DONE, so a reset before then drops it.
  assign w_done        = (r_state == DONE);
  assign w_mem_we      = w_done & r_we & ~w_oor;
  assign w_unused_addr = ^r_addr;

  lc3_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (c_AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (r_addr[c_AW-1:0]),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

  assign dout  = r_dout;
  assign ready = w_done;
  assign err   = w_done & w_oor;

endmodule
`default_nettype wire

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 The block SHALL take parameter MEM_DEPTH, default 256, the number of 16-bit words stored (power of two, 2..65536).
REQ-002 The block SHALL take parameter LATENCY, default 2, the number of clock edges from request sample to response (1..15).
REQ-003 The block SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL provide port memEN  input  1  access request from the LC3 datapath (MAR/MDR side).
REQ-006 The block SHALL provide port memWE  input  1  write qualifier for the request; 1 = write, 0 = read.
REQ-007 The block SHALL provide port addr  input  16  word address, from MAR.
REQ-008 The block SHALL provide port din  input  16  write data, from MDR.
REQ-009 The block SHALL provide port dout  output  16  read data returned to MDR.
REQ-010 The block SHALL provide port ready  output  1  one-cycle completion strobe for the current access.
REQ-011 The block SHALL provide port err  output  1  out-of-range flag (see Configuration).

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE with memEN=1 at a rising edge, the block SHALL capture addr, din, memWE into internal registers, load the countdown counter with LATENCY-1, and enter BUSY.
REQ-014 In BUSY the counter SHALL decrement each edge; on the edge where it reads 0 the FSM SHALL enter DONE.
REQ-015 ready SHALL be 1 only in DONE, for exactly one cycle, starting after edge LATENCY counted from the capture edge (edge 0).
REQ-016 For a read, dout SHALL present mem[captured addr] from the DONE cycle onward and hold it until the next read completes.
REQ-017 For a write, memory SHALL be updated with the captured din on the edge leaving DONE; dout SHALL be unchanged.
REQ-018 DONE SHALL always return to IDLE; memEN still high in that IDLE cycle SHALL start a new access (back-to-back, one idle cycle between strobes).
REQ-019 memEN, memWE, addr, din SHALL be ignored in BUSY and DONE; the captured request is unaffected by input changes.
REQ-020 A read immediately following a write to the same address SHALL return the newly written data.
REQ-021 The address index SHALL be addr modulo MEM_DEPTH, using the low log2(MEM_DEPTH) bits, unless REQ-028 applies.

Reset
REQ-022 While rst=1, the FSM SHALL be IDLE, the counter 0, ready 0, dout 16'h0000, and err 0, independent of clk.
REQ-023 rst asserted mid-access SHALL abort the access and discard any pending write.
REQ-024 Memory array contents SHALL NOT be cleared by rst.
REQ-025 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro LC3_MEM_OOR_ERR_EN SHALL control out-of-range checking.
REQ-027 Without LC3_MEM_OOR_ERR_EN, err SHALL be tied to 0 and addresses SHALL wrap per REQ-021.
REQ-028 With LC3_MEM_OOR_ERR_EN, a captured addr >= MEM_DEPTH SHALL complete normally with ready, suppress the write, return dout 16'h0000 for reads, and assert err in the DONE cycle only.

Structure
REQ-029 Package lc3_mem_pkg SHALL hold the state enum type (IDLE/BUSY/DONE), the default MEM_DEPTH and LATENCY constants, and the counter width constant (4 bits).
REQ-030 Sub-module lc3_mem_array SHALL hold the storage, with a synchronous write port and a combinational read port; the FSM, counter, capture registers and dout register SHALL live in lc3_mem_responder.

Verification
REQ-031 Write 16'hBEEF to addr 16'h0010, then read 16'h0010 (LATENCY=2) -> ready pulses 2 edges after each capture; the read gives dout=16'hBEEF.
REQ-032 Back-to-back: memEN held high for 3 reads of 16'h0001..16'h0003 -> three single-cycle ready strobes, each followed by one IDLE cycle; dout values are correct in order.
REQ-033 Change addr and din during BUSY of a write to 16'h0005 with 16'h1234 -> memory[5]=16'h1234 only; the new values are ignored.
REQ-034 Assert rst in the BUSY cycle of a write of 16'hAAAA to 16'h0007 (previously 16'h5555) -> ready never pulses; dout=0; a later read returns 16'h5555.
REQ-035 Set MEM_DEPTH=256 and access addr 16'h0105 -> without the macro it aliases to index 16'h05; with LC3_MEM_OOR_ERR_EN, err=1 with ready, dout=0, and no write occurs.
REQ-036 Set LATENCY=1 and read -> ready asserts after edge 1; with LATENCY=15, ready asserts after edge 15.
